// File: rtl/jtag_ahb_bridge.sv
// JTAG TAP (IEEE 1149.1) driving single AHB-Lite transfers from Update-DR.
// Optional ADDR_AUTOINC_EN: address register steps by one word after each transfer.
module jtag_ahb_bridge #(
    parameter int          ADDR_WIDTH   = 32,
    parameter int          DATA_WIDTH   = 32,
    parameter int          IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_563D
) (
    input  logic                  TCK,
    input  logic                  RST,
    input  logic                  TMS,
    input  logic                  TDI,
    output logic                  TDO,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HRESP,
    output logic                  HWRITE,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HSIZE,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [DATA_WIDTH-1:0] HWDATA
);
    localparam int DR_W = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;
    localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(4'h8);
    localparam logic [IR_WIDTH-1:0] OP_ADDR   = IR_WIDTH'(4'h4);
    localparam logic [IR_WIDTH-1:0] OP_WDATA  = IR_WIDTH'(4'hC);
    localparam logic [IR_WIDTH-1:0] OP_RDATA  = IR_WIDTH'(4'h2);
    localparam logic [IR_WIDTH-1:0] OP_STATUS = IR_WIDTH'(4'hA);
    localparam logic [DR_W-1:0] M_BYP = DR_W'(1);
    localparam logic [DR_W-1:0] M_ID  = DR_W'(1) << 31;
    localparam logic [DR_W-1:0] M_AD  = DR_W'(1) << (ADDR_WIDTH - 1);
    localparam logic [DR_W-1:0] M_DT  = DR_W'(1) << (DATA_WIDTH - 1);
    localparam logic [2:0] HSIZE_C = (DATA_WIDTH == 8) ? 3'd0 : (DATA_WIDTH == 16) ? 3'd1 : 3'd2;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_e;
    typedef enum logic [1:0] {B_IDLE, B_ADDR, B_DATA} bus_e;
    typedef enum logic [2:0] {I_BYP, I_IDC, I_ADR, I_WD, I_RD, I_ST} sel_e;

    tap_e tap_q, tap_d;
    bus_e bus_q, bus_d;
    sel_e sel;

    logic [IR_WIDTH-1:0]   ir_q, ir_sr_q;
    logic [DR_W-1:0]       dr_q, dr_shift, cap_val, msb;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic                  write_q, bus_err_q, overrun_q;
    logic                  busy, done, upd_dr, req, collide;

    // TAP state machine
    always_ff @(posedge TCK) begin
        if (RST) tap_q <= TLR;
        else     tap_q <= tap_d;
    end

    always_comb begin
        tap_d = tap_q;
        case (tap_q)
            TLR:    tap_d = TMS ? TLR    : RTI;
            RTI:    tap_d = TMS ? SEL_DR : RTI;
            SEL_DR: tap_d = TMS ? SEL_IR : CAP_DR;
            CAP_DR: tap_d = TMS ? EX1_DR : SH_DR;
            SH_DR:  tap_d = TMS ? EX1_DR : SH_DR;
            EX1_DR: tap_d = TMS ? UPD_DR : PAU_DR;
            PAU_DR: tap_d = TMS ? EX2_DR : PAU_DR;
            EX2_DR: tap_d = TMS ? UPD_DR : SH_DR;
            UPD_DR: tap_d = TMS ? SEL_DR : RTI;
            SEL_IR: tap_d = TMS ? TLR    : CAP_IR;
            CAP_IR: tap_d = TMS ? EX1_IR : SH_IR;
            SH_IR:  tap_d = TMS ? EX1_IR : SH_IR;
            EX1_IR: tap_d = TMS ? UPD_IR : PAU_IR;
            PAU_IR: tap_d = TMS ? EX2_IR : PAU_IR;
            EX2_IR: tap_d = TMS ? UPD_IR : SH_IR;
            UPD_IR: tap_d = TMS ? SEL_DR : RTI;
            default: tap_d = TLR;
        endcase
    end

    always_comb begin
        TDO    = 1'b0;
        upd_dr = (tap_q == UPD_DR);
        if (tap_q == SH_IR)      TDO = ir_sr_q[0];
        else if (tap_q == SH_DR) TDO = dr_q[0];
    end

    // Undefined codes, including all-ones, fall through to BYPASS
    always_comb begin
        sel = I_BYP;
        if      (ir_q == OP_IDCODE) sel = I_IDC;
        else if (ir_q == OP_ADDR)   sel = I_ADR;
        else if (ir_q == OP_WDATA)  sel = I_WD;
        else if (ir_q == OP_RDATA)  sel = I_RD;
        else if (ir_q == OP_STATUS) sel = I_ST;
    end

    always_comb begin
        cap_val = '0;
        msb     = M_BYP;
        case (sel)
            I_IDC: begin cap_val = DR_W'(IDCODE_VALUE); msb = M_ID; end
            I_ADR: begin cap_val = DR_W'(addr_q);       msb = M_AD; end
            I_WD:  begin cap_val = DR_W'(wdata_q);      msb = M_DT; end
            I_RD:  begin cap_val = DR_W'(rdata_q);      msb = M_DT; end
            I_ST:  begin cap_val = DR_W'({overrun_q, bus_err_q, busy}); msb = M_DT; end
            default: ;
        endcase
        dr_shift = ((dr_q >> 1) & ~msb) | (TDI ? msb : '0);
    end

    // Bus state machine
    always_ff @(posedge TCK) begin
        if (RST) bus_q <= B_IDLE;
        else     bus_q <= bus_d;
    end

    always_comb begin
        bus_d = bus_q;
        case (bus_q)
            B_IDLE: if (req)    bus_d = B_ADDR;
            B_ADDR: if (HREADY) bus_d = B_DATA;
            B_DATA: if (HREADY) bus_d = B_IDLE;
            default: bus_d = B_IDLE;
        endcase
    end

    always_comb begin
        busy    = (bus_q != B_IDLE);
        done    = (bus_q == B_DATA) && HREADY;
        HTRANS  = (bus_q == B_ADDR) ? 2'b10 : 2'b00;
        HWRITE  = (bus_q == B_ADDR) && write_q;
        HADDR   = addr_q;
        HWDATA  = wdata_q;
        HSIZE   = HSIZE_C;
        req     = upd_dr && (sel == I_WD || sel == I_RD) && !busy;
        collide = upd_dr && (sel == I_WD || sel == I_RD || sel == I_ADR) && busy;
    end

    always_ff @(posedge TCK) begin
        if (RST) begin
            ir_q      <= OP_IDCODE;
            ir_sr_q   <= '0;
            dr_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            write_q   <= 1'b0;
            bus_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (tap_q)
                CAP_IR: ir_sr_q <= IR_WIDTH'(1);
                SH_IR:  ir_sr_q <= {TDI, ir_sr_q[IR_WIDTH-1:1]};
                UPD_IR: ir_q    <= ir_sr_q;
                CAP_DR: dr_q    <= cap_val;
                SH_DR:  dr_q    <= dr_shift;
                default: ;
            endcase
            if (upd_dr && !busy) begin
                if (sel == I_ADR) addr_q  <= dr_q[ADDR_WIDTH-1:0];
                if (sel == I_WD)  wdata_q <= dr_q[DATA_WIDTH-1:0];
            end
            if (req) write_q <= (sel == I_WD);
            if (upd_dr && sel == I_ST) begin
                if (dr_q[2]) overrun_q <= 1'b0;
                if (dr_q[1]) bus_err_q <= 1'b0;
            end
            if (collide) overrun_q <= 1'b1;
            if (done) begin
                if (!write_q) rdata_q <= HRDATA;
                if (HRESP)    bus_err_q <= 1'b1;
`ifdef ADDR_AUTOINC_EN
                addr_q <= addr_q + ADDR_WIDTH'(DATA_WIDTH / 8);
`endif
            end
            // TLR entry wins over everything else; the bus transfer keeps running
            if (tap_d == TLR) ir_q <= OP_IDCODE;
            if (tap_d == TLR && tap_q != TLR) begin
                overrun_q <= 1'b0;
                bus_err_q <= 1'b0;
            end
        end
    end
endmodule

// File: doc/jtag_ahb_bridge.md
Name: jtag_ahb_bridge

Overview:
Parametrised next-generation JTAG TAP with an AHB-Lite master back end, used as the debug access port into the SoC bus. The TAP shifts address and data over TDI/TDO. Update-DR of the WDATA and RDATA registers launches single AHB-Lite transfers. Compared with the previous controller it adds configurable address/data/IR widths, HREADY wait-state handling, a sticky STATUS register (busy, bus error, overrun) and optional address auto-increment.

Parameters:
ADDR_WIDTH, 32, width of HADDR and of the ADDR data register
DATA_WIDTH, 32, width of HWDATA/HRDATA and of the WDATA/RDATA/STATUS registers; must be 8, 16 or 32
IR_WIDTH, 4, instruction register length; must be 4 or more
IDCODE_VALUE, 32'h1000_563D, value captured by IDCODE; bit 0 must be 1

Ports:
TCK  in  1  sole clock; all state updates on the rising edge
RST  in  1  synchronous active-high reset
TMS  in  1  TAP mode select
TDI  in  1  serial data in, LSB first
TDO  out  1  serial data out
HREADY  in  1  AHB-Lite transfer done / wait
HRDATA  in  DATA_WIDTH  AHB read data
HRESP  in  1  AHB error response
HWRITE  out  1  1 = write
HTRANS  out  2  2'b00 IDLE, 2'b10 NONSEQ
HSIZE  out  3  constant log2(DATA_WIDTH/8)
HADDR  out  ADDR_WIDTH  transfer address
HWDATA  out  DATA_WIDTH  write data

Behaviour:
- Reset: RST=1 at a TCK edge puts the TAP in Test-Logic-Reset and sets IR=IDCODE. It clears the address, wdata, rdata and STATUS registers and aborts the bus FSM to B_IDLE. Output reset values: TDO=0, HTRANS=00, HWRITE=0, HADDR=0, HWDATA=0.
- TAP FSM: the standard 16-state IEEE 1149.1 machine, advancing on TMS.
  - Five TMS=1 edges reach Test-Logic-Reset from any state.
  - Entering Test-Logic-Reset sets IR=IDCODE and clears STATUS sticky bits.
  - It does not abort an in-flight bus transfer.
- Instruction codes (IR value; IR is shifted LSB first; codes are zero-extended to IR_WIDTH):
  - BYPASS 0x0, IDCODE 0x8, ADDR 0x4, WDATA 0xC, RDATA 0x2, STATUS 0xA.
  - All-ones and any other undefined code select BYPASS.
  - Capture-IR loads ...01 into the IR shift register.
- DR lengths: BYPASS 1, IDCODE 32, ADDR ADDR_WIDTH, WDATA/RDATA/STATUS DATA_WIDTH.
- Shift: right shift with TDI into the MSB. TDO = shift_reg[0] combinationally while in Shift-IR or Shift-DR, else 0.
- Capture-DR loads, per selected register:
  - BYPASS: 0
  - IDCODE: IDCODE_VALUE
  - ADDR: current address register
  - WDATA: last written data
  - RDATA: rdata register
  - STATUS: {0.., overrun, bus_err, busy}
- Update-DR:
  - ADDR loads the address register.
  - WDATA loads wdata and requests a write.
  - RDATA requests a read; the result is shifted out on the next RDATA Capture-DR.
  - STATUS is write-1-to-clear on bits [2:1].
- Bus FSM:
  - B_IDLE: on a request, go to B_ADDR on the next edge.
  - B_ADDR: HTRANS=10, HADDR=address, HWRITE=request type. Held until sampled with HREADY=1, then go to B_DATA.
  - B_DATA: HTRANS=00. For writes HWDATA=wdata. Wait while HREADY=0. On HREADY=1:
    - for reads, latch HRDATA into rdata;
    - if HRESP=1, set bus_err;
    - return to B_IDLE.
  - busy=1 whenever not in B_IDLE.
- Request latency: the Update-DR edge is followed by B_ADDR on the next edge. With HREADY high, a transfer takes 3 edges total.
- Collision: an Update-DR request (WDATA/RDATA) while busy=1 is dropped and sets overrun. ADDR update while busy is also dropped and sets overrun.
- Bus error: rdata is still latched on an errored read. bus_err is sticky until W1C or reset.

Optional Feature:
ADDR_AUTOINC_EN defined:
- On each completed transfer (B_DATA with HREADY=1), the address register increments by DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH.
- Errored transfers increment too.
- Repeated WDATA/RDATA accesses stream consecutive words.

ADDR_AUTOINC_EN not defined:
- The address changes only via ADDR Update-DR.

Test Plan:
- RST then 5×TMS=1, Shift-DR of 32 bits -> TDO streams 0x1000563D LSB first (IR defaults to IDCODE).
- IR=ADDR, shift 0x89ABCDEF, Update, then shift again -> captured value 0x89ABCDEF out on TDO; HTRANS stays 00.
- IR=WDATA, shift 0xDEADBEEF, Update with HREADY=1 -> exactly one cycle with HTRANS=10, HADDR=0x89ABCDEF, HWRITE=1; next cycle HWDATA=0xDEADBEEF, HTRANS=00.
- IR=RDATA, Update with HRDATA=0x0000F00F, HREADY held low 3 cycles in the data phase -> FSM stays in B_DATA with busy=1. Next RDATA capture shifts out 0x0000F00F.
- Read with HRESP=1 -> STATUS reads 0x2. Second WDATA Update issued while busy -> STATUS 0x6 (0x7 if still busy). Write 0x6 to STATUS -> reads 0x0.
- With ADDR_AUTOINC_EN: ADDR=0xFFFFFFFC, two writes -> HADDR 0xFFFFFFFC then 0x00000000. Without it -> both 0xFFFFFFFC.
